seg_display_driver: RTL
=======================

Name: seg_display_driver

Overview:
- Downstream consumer of the 8-bit loadable counter output `Q`.
- Converts the unsigned 8-bit count to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a 3-digit, common-anode, time-multiplexed 7-segment display with leading-zero blanking.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays enabled; legal range ≥ 2; the bench uses 4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- value  input  8  unsigned count to display (counter `Q`)
- busy  output  1  high while a conversion is in progress (states SHIFT, DONE)
- an  output  3  digit enables, active low; an[0]=ones, an[1]=tens, an[2]=hundreds
- seg  output  7  segments {g,f,e,d,c,b,a}, active low

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, busy=0, last_value=0, display register {h,t,o}=0,0,0.
  - Scan divider=0, digit index=0, an=3'b110, seg=7'b1000000 (shows "0").
- Converter FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Each edge compares `value` with `last_value`.
  - If they differ: latch value into shift register and last_value, clear 12-bit BCD accumulator, iteration counter=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each edge performs one iteration.
  - For each BCD nibble ≥5, add 3.
  - Then shift {bcd, bin} left by 1.
  - Iteration counter+1; after the 8th iteration go to DONE.
- DONE: one edge loads the display register from the accumulator, then go to IDLE.
- Latency:
  - Sampling edge E0 → iterations on E1..E8 → display register updated on E9.
  - IDLE again from E9; earliest next sample on E10.
- Changes of `value` while busy=1 are ignored. IDLE re-detects any difference afterwards, so the final value is always displayed; intermediate values may be skipped.
- Display register changes only in DONE, so there are no partial or garbled digits.
- BCD nibble widths: hundreds ≤2, tens ≤9, ones ≤9; the accumulator never exceeds 12 bits for 8-bit input.
- Scanner:
  - Free-running divider counts 0..SCAN_DIV-1.
  - On terminal count: divider→0, digit index advances 0→1→2→0.
  - an and seg are registered, updated on the same edge as the index (one-hot low per index).
- Segment decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - Hundreds digit shows 1111111 when h=0.
  - Tens digit shows 1111111 when h=0 and t=0.
  - Ones is always shown.
- Registered seg reflects a display-register update on the first edge after E9 at which that digit is selected or re-registered; seg is recomputed every edge from the current index.
- Reset mid-conversion aborts immediately: state IDLE, display "0", last_value=0. After release, a nonzero `value` triggers a new conversion on the first edge.
- Scanner runs independently of the converter; busy never stalls scanning.

Test Plan:
- Reset, value=0, SCAN_DIV=4 → an=110, seg=1000000. During tens/hundreds slots (an=101/011) seg=1111111; busy stays 0 (no conversion).
- value=8'd255 after reset → busy=1 for exactly 9 cycles starting the edge after sampling. Display register=2,5,5 on E9. Scan shows ones 0010010, tens 0010010, hundreds 0100100.
- value=8'd7 → ones 1111000, tens and hundreds 1111111. Then value=8'd40 → ones 1000000, tens 0011001, hundreds blank.
- value=8'd100; 3 cycles into conversion change to 8'd42 → display becomes 1,0,0 at E9. A second conversion starts at E10 and display becomes 0,4,2 nine edges later, hundreds blanked.
- SCAN_DIV=4, constant value → an sequence 110,101,011,110 with each held exactly 4 cycles; verify wrap over ≥3 full rotations.
- Assert rst asynchronously mid-SHIFT with value=8'd128 → an=110 and seg=1000000 immediately, without a clock edge. After release, display shows 1,2,8 nine edges after the first sampling edge.

Source files
------------

// File: rtl/seg_display_driver.sv
// Shows an 8-bit unsigned count on a 3-digit common-anode multiplexed 7-segment display.
// A serial double-dabble converter feeds the display register; an independent scanner drives the pins.
module seg_display_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic       busy,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic        busy_q;
  logic [7:0]  last_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [2:0]  iter_q;
  logic [3:0]  hun_q;
  logic [3:0]  ten_q;
  logic [3:0]  one_q;

  logic [DW-1:0] div_q;
  logic          div_tc;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [2:0]    an_q;
  logic [2:0]    an_d;
  logic [6:0]    seg_q;
  logic [6:0]    seg_d;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign bcd_adj = add3(bcd_q);

  // Display digits only change in DONE, so the scanner never sees a half-converted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      last_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (value != last_q) begin
            bin_q   <= value;
            last_q  <= value;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) state_q <= DONE;
        end
        DONE: begin
          hun_q   <= bcd_q[11:8];
          ten_q   <= bcd_q[7:4];
          one_q   <= bcd_q[3:0];
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    div_tc = (div_q == DW'(SCAN_DIV - 1));
    idx_d  = idx_q;
    if (div_tc) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  // Outputs are computed from the next index so an and seg switch on the same edge as it.
  always_comb begin
    an_d  = 3'b111;
    seg_d = 7'b1111111;
    case (idx_d)
      2'd0: begin
        an_d  = 3'b110;
        seg_d = decode(one_q);
      end
      2'd1: begin
        an_d  = 3'b101;
        seg_d = (hun_q == 4'd0 && ten_q == 4'd0) ? 7'b1111111 : decode(ten_q);
      end
      2'd2: begin
        an_d  = 3'b011;
        seg_d = (hun_q == 4'd0) ? 7'b1111111 : decode(hun_q);
      end
      default: begin
        an_d  = 3'b111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 3'b110;
      seg_q <= 7'b1000000;
    end else begin
      div_q <= div_tc ? '0 : div_q + 1'b1;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule
